bus_lsu: RTL and testbench

//  Load/store sequencer that executes one bus instruction at a time: op, data_type, data_reg, addr_reg, addr_offset.

---
 rtl/bus_lsu_pkg.sv | 38 +++
 rtl/bus_lsu_align.sv | 58 +++++
 rtl/bus_lsu.sv | 198 +++++++++++++++++++
 tb/tb_bus_lsu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_lsu_pkg.sv
// rtl/bus_lsu_pkg.sv - shared types and helpers for the bus load/store sequencer
// Purpose: instruction opcode, access size and FSM state encodings, plus the
//          access-size-to-byte-count helper used by the lane logic.
// Ports:   none (package).
package bus_lsu_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_t;

   // B/W/L/Q = 1/2/4/8 bytes
   typedef enum logic [1:0] {
      DT_B = 2'd0,
      DT_W = 2'd1,
      DT_L = 2'd2,
      DT_Q = 2'd3
   } data_type_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACCESS,
      ST_WAIT,
      ST_WB
   } state_t;

   function automatic int size_bytes(data_type_t dt);
      case (dt)
         DT_B:    return 1;
         DT_W:    return 2;
         DT_L:    return 4;
         default: return 8;
      endcase
   endfunction

endpackage

// File: rtl/bus_lsu_align.sv
// rtl/bus_lsu_align.sv - byte-lane steering for the load/store sequencer
// Purpose: purely combinational size/lane handling.
// Ports:
//   data_type       access size
//   addr_lo         low byte-address bits of the freshly computed address
//   lane            byte lane of the registered (aligned) address
//   st_data         store source word
//   ld_word         raw RAM read word
//   misalign        addr_lo is not a multiple of the access size
//   addr_lo_aligned addr_lo with the bits below the access size cleared
//   be              byte enables for a store at this lane
//   st_shifted      store data moved up to its lane
//   ld_value        load data moved down from its lane, zero-extended to size
module bus_lsu_align
   import bus_lsu_pkg::*;
#(
   parameter  int DATAW = 64,
   localparam int BEW   = DATAW / 8,
   localparam int LANEW = $clog2(BEW)
) (
   input  data_type_t       data_type,
   input  logic [LANEW-1:0] addr_lo,
   input  logic [LANEW-1:0] lane,
   input  logic [DATAW-1:0] st_data,
   input  logic [DATAW-1:0] ld_word,
   output logic             misalign,
   output logic [LANEW-1:0] addr_lo_aligned,
   output logic [BEW-1:0]   be,
   output logic [DATAW-1:0] st_shifted,
   output logic [DATAW-1:0] ld_value
);

   int               nbytes;
   logic [LANEW-1:0] low_mask;
   logic [BEW-1:0]   size_mask;
   logic [DATAW-1:0] data_mask;
   logic [LANEW+2:0] bit_shift;

   always_comb begin
      nbytes    = size_bytes(data_type);
      low_mask  = LANEW'(nbytes - 1);
      size_mask = '0;
      data_mask = '0;
      for (int i = 0; i < BEW; i++) begin
         if (i < nbytes) begin
            size_mask[i]        = 1'b1;
            data_mask[8*i +: 8] = 8'hFF;
         end
      end
      bit_shift       = {lane, 3'b000};
      misalign        = |(addr_lo & low_mask);
      addr_lo_aligned = addr_lo & ~low_mask;
      be              = size_mask << lane;
      st_shifted      = st_data << bit_shift;
      ld_value        = (ld_word >> bit_shift) & data_mask;
   end

endmodule

// File: rtl/bus_lsu.sv
// rtl/bus_lsu.sv - one-at-a-time load/store sequencer between decoder, register file and data RAM
// Purpose: accepts one instruction per valid/ready handshake, forms
//          address = reg[addr_reg] + sign-extended addr_offset, then moves
//          RAM->reg (LOAD) or reg->RAM (STORE). NOP retires in the address cycle.
// Build option: BUS_LSU_MISALIGN_TRAP_EN - when defined, misaligned LOAD/STORE
//          pulse err and are dropped; otherwise the address is silently aligned
//          down and err stays 0.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready               instruction handshake (ready only in IDLE)
//   op, data_type, data_reg,
//   addr_reg, addr_offset             instruction fields
//   reg_raddr0/reg_rdata0             base register read (combinational file)
//   reg_raddr1/reg_rdata1             store data register read
//   reg_we/reg_waddr/reg_wdata        load write-back
//   ram_en/ram_we/ram_addr/ram_be/
//   ram_wdata/ram_rdata               data RAM port, word addressed
//   done                              instruction retired pulse
//   err                               misaligned trap pulse
module bus_lsu
   import bus_lsu_pkg::*;
#(
   parameter  int REG_ADDRW = 4,
   parameter  int DATAW     = 64,
   parameter  int RAM_ADDRW = 16,
   parameter  int RAM_LAT   = 1,
   localparam int BEW       = DATAW / 8,
   localparam int LANEW     = $clog2(BEW)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  op_t                        op,
   input  data_type_t                 data_type,
   input  logic [REG_ADDRW-1:0]       data_reg,
   input  logic [REG_ADDRW-1:0]       addr_reg,
   input  logic [RAM_ADDRW-1:0]       addr_offset,
   output logic [REG_ADDRW-1:0]       reg_raddr0,
   input  logic [DATAW-1:0]           reg_rdata0,
   output logic [REG_ADDRW-1:0]       reg_raddr1,
   input  logic [DATAW-1:0]           reg_rdata1,
   output logic                       reg_we,
   output logic [REG_ADDRW-1:0]       reg_waddr,
   output logic [DATAW-1:0]           reg_wdata,
   output logic                       ram_en,
   output logic                       ram_we,
   output logic [RAM_ADDRW-LANEW-1:0] ram_addr,
   output logic [BEW-1:0]             ram_be,
   output logic [DATAW-1:0]           ram_wdata,
   input  logic [DATAW-1:0]           ram_rdata,
   output logic                       done,
   output logic                       err
);

   localparam int CNTW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   state_t               state, state_d;
   op_t                  op_q;
   data_type_t           dt_q;
   logic [REG_ADDRW-1:0] data_reg_q, addr_reg_q;
   logic [RAM_ADDRW-1:0] offset_q, addr_q, addr_sum, addr_eff;
   logic [DATAW-1:0]     st_data_q, ld_value_q;
   logic [CNTW-1:0]      cnt_q;
   logic                 is_mem_op;

   logic                 misalign;
   logic [LANEW-1:0]     lo_aligned;
   logic [BEW-1:0]       be_w;
   logic [DATAW-1:0]     st_shifted, ld_value;

   // Only the low RAM_ADDRW bits of the base register form an address.
   logic                 unused_base_hi;
   assign unused_base_hi = ^reg_rdata0[DATAW-1:RAM_ADDRW];

   assign reg_raddr0 = addr_reg_q;
   assign reg_raddr1 = data_reg_q;
   assign addr_sum   = reg_rdata0[RAM_ADDRW-1:0] + offset_q;
   // With the trap enabled a misaligned access never reaches ACCESS, so the
   // aligned form only ever matters when the trap is compiled out.
   assign addr_eff   = misalign ? {addr_sum[RAM_ADDRW-1:LANEW], lo_aligned} : addr_sum;
   assign is_mem_op  = (op_q == OP_LOAD) || (op_q == OP_STORE);

   bus_lsu_align #(.DATAW(DATAW)) u_align (
      .data_type       (dt_q),
      .addr_lo         (addr_sum[LANEW-1:0]),
      .lane            (addr_q[LANEW-1:0]),
      .st_data         (st_data_q),
      .ld_word         (ram_rdata),
      .misalign        (misalign),
      .addr_lo_aligned (lo_aligned),
      .be              (be_w),
      .st_shifted      (st_shifted),
      .ld_value        (ld_value)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         op_q       <= OP_NOP;
         dt_q       <= DT_B;
         data_reg_q <= '0;
         addr_reg_q <= '0;
         offset_q   <= '0;
         addr_q     <= '0;
         st_data_q  <= '0;
         ld_value_q <= '0;
         cnt_q      <= '0;
      end else begin
         state <= state_d;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q       <= op;
                  dt_q       <= data_type;
                  data_reg_q <= data_reg;
                  addr_reg_q <= addr_reg;
                  offset_q   <= addr_offset;
               end
            end
            ST_ADDR: begin
               addr_q    <= addr_eff;
               st_data_q <= reg_rdata1;
            end
            ST_ACCESS: cnt_q <= CNTW'(RAM_LAT - 1);
            ST_WAIT: begin
               // RAM data is valid exactly in the cycle the countdown hits zero.
               if (cnt_q == '0) ld_value_q <= ld_value;
               else             cnt_q      <= cnt_q - CNTW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state;
      req_ready = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_be    = '0;
      ram_wdata = '0;
      reg_we    = 1'b0;
      reg_waddr = '0;
      reg_wdata = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (!is_mem_op) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end else begin
`ifdef BUS_LSU_MISALIGN_TRAP_EN
               if (misalign) begin
                  err     = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ACCESS;
               end
`else
               state_d = ST_ACCESS;
`endif
            end
         end
         ST_ACCESS: begin
            ram_en   = 1'b1;
            ram_addr = addr_q[RAM_ADDRW-1:LANEW];
            if (op_q == OP_STORE) begin
               ram_we    = 1'b1;
               ram_be    = be_w;
               ram_wdata = st_shifted;
               done      = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_WB;
         end
         ST_WB: begin
            reg_we    = 1'b1;
            reg_waddr = data_reg_q;
            reg_wdata = ld_value_q;
            done      = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_lsu.sv
// tb/tb_bus_lsu.sv - self-checking bench for bus_lsu
module tb_bus_lsu;
   import bus_lsu_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   op_t         op;
   data_type_t  data_type;
   logic [3:0]  data_reg, addr_reg;
   logic [15:0] addr_offset;
   logic [3:0]  reg_raddr0, reg_raddr1, reg_waddr;
   logic [63:0] reg_rdata0, reg_rdata1, reg_wdata;
   logic        reg_we;
   logic        ram_en, ram_we;
   logic [12:0] ram_addr;
   logic [7:0]  ram_be;
   logic [63:0] ram_wdata, ram_rdata;
   logic        done, err;

   always #5 clk = ~clk;

   bus_lsu #(.REG_ADDRW(4), .DATAW(64), .RAM_ADDRW(16), .RAM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .data_type(data_type), .data_reg(data_reg), .addr_reg(addr_reg),
      .addr_offset(addr_offset), .reg_raddr0(reg_raddr0), .reg_rdata0(reg_rdata0),
      .reg_raddr1(reg_raddr1), .reg_rdata1(reg_rdata1), .reg_we(reg_we),
      .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .done(done), .err(err)
   );

   // Register file: combinational reads, contents set only by the stimulus.
   logic [63:0] regs [16];
   assign reg_rdata0 = regs[reg_raddr0];
   assign reg_rdata1 = regs[reg_raddr1];

   // RAM: read data appears exactly LAT cycles after ram_en, garbage otherwise.
   logic [63:0] mem [8192];
   logic [63:0] pipe_d [LAT];
   logic        pipe_v [LAT];
   always @(posedge clk) begin
      pipe_v[0] <= ram_en && !ram_we;
      pipe_d[0] <= mem[ram_addr];
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign ram_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

   typedef struct {
      op_t         op;
      data_type_t  dt;
      logic [3:0]  dr;
      logic [3:0]  ar;
      logic [63:0] base;
      logic [15:0] off;
      logic [63:0] sval;
      logic        pre;
      logic [12:0] pre_addr;
      logic [63:0] pre_word;
      int          lat;
      int          en;
      logic [12:0] addr;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic [63:0] rwdata;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   int checks = 0;
   int errors = 0;

   int          c_lat, c_en, c_regwe;
   logic        c_we, c_err;
   logic [12:0] c_addr;
   logic [7:0]  c_be;
   logic [63:0] c_wdata, c_rwdata;
   logic [3:0]  c_waddr;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Issue one instruction on an idle unit and record what happens up to done/err.
   task automatic issue(input op_t o, input data_type_t d, input logic [3:0] dr,
                        input logic [3:0] ar, input logic [15:0] off);
      bit fin;
      @(negedge clk);
      op = o; data_type = d; data_reg = dr; addr_reg = ar; addr_offset = off;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      c_lat = 0; c_en = 0; c_regwe = 0; c_err = 1'b0; c_we = 1'b0;
      c_addr = '0; c_be = '0; c_wdata = '0; c_rwdata = '0; c_waddr = '0;
      fin = 1'b0;
      for (int c = 1; c <= 20 && !fin; c++) begin
         if (ram_en) begin
            c_en++;
            c_addr = ram_addr; c_we = ram_we; c_be = ram_be; c_wdata = ram_wdata;
            if (ram_we)
               for (int b = 0; b < 8; b++)
                  if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
         end
         if (reg_we) begin
            c_regwe++;
            c_waddr = reg_waddr; c_rwdata = reg_wdata;
         end
         if (err) c_err = 1'b1;
         if (done || err) begin
            c_lat = c;
            fin = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   initial begin
      vec_t v;
      bit   seen;

      for (int i = 0; i < 8192; i++) mem[i] = '0;
      for (int i = 0; i < 16; i++) regs[i] = '0;

      //           op        dt    dr     ar     base                    off       sval                   pre   pre_addr  pre_word               lat en addr     be     wdata                  rwdata                 err
      vecs.push_back('{OP_LOAD,  DT_Q, 4'd2,  4'd1,  64'hFFFF_0000_0000_0100, 16'h0008, 64'h0,                 1'b1, 13'h021, 64'h1122334455667788, 5, 1, 13'h021, 8'h00, 64'h0,                 64'h1122334455667788, 1'b0});
      vecs.push_back('{OP_LOAD,  DT_B, 4'd6,  4'd4,  64'h0100,                16'h0003, 64'h0,                 1'b1, 13'h020, 64'hDDCCBBAA99887766, 5, 1, 13'h020, 8'h00, 64'h0,                 64'h99,               1'b0});
      vecs.push_back('{OP_STORE, DT_W, 4'd3,  4'd5,  64'h0200,                16'h0002, 64'hBEEF,              1'b0, 13'h000, 64'h0,                2, 1, 13'h040, 8'h0C, 64'h00000000BEEF0000, 64'h0,                1'b0});
      vecs.push_back('{OP_LOAD,  DT_W, 4'd7,  4'd5,  64'h0200,                16'h0002, 64'h0,                 1'b0, 13'h000, 64'h0,                5, 1, 13'h040, 8'h00, 64'h0,                 64'hBEEF,             1'b0});
      vecs.push_back('{OP_STORE, DT_Q, 4'd8,  4'd9,  64'h0010,                16'hFFF8, 64'h0123456789ABCDEF,  1'b0, 13'h000, 64'h0,                2, 1, 13'h001, 8'hFF, 64'h0123456789ABCDEF, 64'h0,                1'b0});
      vecs.push_back('{OP_LOAD,  DT_L, 4'd10, 4'd11, 64'h0004,                16'hFFF8, 64'h0,                 1'b1, 13'h1FFF, 64'hCAFEF00D12345678, 5, 1, 13'h1FFF, 8'h00, 64'h0,                64'hCAFEF00D,         1'b0});
      vecs.push_back('{OP_NOP,   DT_Q, 4'd1,  4'd12, 64'h0,                   16'h0000, 64'h0,                 1'b0, 13'h000, 64'h0,                1, 0, 13'h000, 8'h00, 64'h0,                 64'h0,                1'b0});
`ifdef BUS_LSU_MISALIGN_TRAP_EN
      vecs.push_back('{OP_LOAD,  DT_L, 4'd13, 4'd4,  64'h0100,                16'h0002, 64'h0,                 1'b0, 13'h000, 64'h0,                1, 0, 13'h000, 8'h00, 64'h0,                 64'h0,                1'b1});
`else
      vecs.push_back('{OP_LOAD,  DT_L, 4'd13, 4'd4,  64'h0100,                16'h0002, 64'h0,                 1'b0, 13'h000, 64'h0,                5, 1, 13'h020, 8'h00, 64'h0,                 64'h99887766,         1'b0});
`endif
      vecs.push_back('{OP_LOAD,  DT_W, 4'd0,  4'd1,  64'h0100,                16'h000A, 64'h0,                 1'b0, 13'h000, 64'h0,                5, 1, 13'h021, 8'h00, 64'h0,                 64'h5566,             1'b0});
      vecs.push_back('{OP_STORE, DT_B, 4'd14, 4'd12, 64'h0300,                16'h0007, 64'hA5,                1'b0, 13'h000, 64'h0,                2, 1, 13'h060, 8'h80, 64'hA500000000000000, 64'h0,                1'b0});
`ifdef BUS_LSU_MISALIGN_TRAP_EN
      vecs.push_back('{OP_STORE, DT_Q, 4'd15, 4'd12, 64'h0100,                16'h0004, 64'h55AA,              1'b0, 13'h000, 64'h0,                1, 0, 13'h000, 8'h00, 64'h0,                 64'h0,                1'b1});
      vecs.push_back('{OP_LOAD,  DT_Q, 4'd1,  4'd12, 64'h0100,                16'h0000, 64'h0,                 1'b0, 13'h000, 64'h0,                5, 1, 13'h020, 8'h00, 64'h0,                 64'hDDCCBBAA99887766, 1'b0});
`else
      vecs.push_back('{OP_STORE, DT_Q, 4'd15, 4'd12, 64'h0100,                16'h0004, 64'h55AA,              1'b0, 13'h000, 64'h0,                2, 1, 13'h020, 8'hFF, 64'h55AA,              64'h0,                1'b0});
      vecs.push_back('{OP_LOAD,  DT_Q, 4'd1,  4'd12, 64'h0100,                16'h0000, 64'h0,                 1'b0, 13'h000, 64'h0,                5, 1, 13'h020, 8'h00, 64'h0,                 64'h55AA,             1'b0});
`endif

      // Reset state
      rst = 1'b1; req_valid = 1'b0; op = OP_NOP; data_type = DT_B;
      data_reg = '0; addr_reg = '0; addr_offset = '0;
      repeat (2) @(negedge clk);
      chk("reset req_ready", req_ready, 1);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset ram_en", ram_en, 0);
      chk("reset reg_we", reg_we, 0);
      chk("reset raddr0", reg_raddr0, 0);
      rst = 1'b0;

      // Vector table
      foreach (vecs[i]) begin
         v = vecs[i];
         regs[v.ar] = v.base;
         if (v.op == OP_STORE) regs[v.dr] = v.sval;
         if (v.pre) mem[v.pre_addr] = v.pre_word;
         issue(v.op, v.dt, v.dr, v.ar, v.off);
         chk($sformatf("v%0d latency", i), c_lat, v.lat);
         chk($sformatf("v%0d ram_en count", i), c_en, v.en);
         chk($sformatf("v%0d err", i), c_err, v.err);
         if (v.en != 0) begin
            chk($sformatf("v%0d ram_addr", i), c_addr, v.addr);
            chk($sformatf("v%0d ram_we", i), c_we, v.op == OP_STORE);
            if (v.op == OP_STORE) begin
               chk($sformatf("v%0d ram_be", i), c_be, v.be);
               chk($sformatf("v%0d ram_wdata", i), c_wdata, v.wdata);
               chk($sformatf("v%0d reg_we count", i), c_regwe, 0);
            end else begin
               chk($sformatf("v%0d reg_we count", i), c_regwe, 1);
               chk($sformatf("v%0d reg_waddr", i), c_waddr, v.dr);
               chk($sformatf("v%0d reg_wdata", i), c_rwdata, v.rwdata);
            end
         end else begin
            chk($sformatf("v%0d reg_we count", i), c_regwe, 0);
         end
      end

      // Reset while a load is waiting on RAM
      regs[1] = 64'h0100;
      @(negedge clk);
      op = OP_LOAD; data_type = DT_Q; data_reg = 4'd2; addr_reg = 4'd1; addr_offset = 16'h0008;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_seq ram_en in access", ram_en, 1);
      @(negedge clk);
      chk("rst_seq raddr0 before reset", reg_raddr0, 1);
      rst = 1'b1;
      #1;
      chk("rst_seq req_ready", req_ready, 1);
      chk("rst_seq ram_en", ram_en, 0);
      chk("rst_seq reg_we", reg_we, 0);
      chk("rst_seq done", done, 0);
      chk("rst_seq raddr0", reg_raddr0, 0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (reg_we || done || ram_en) seen = 1'b1;
      end
      chk("rst_seq quiet", seen, 0);
      rst = 1'b0;
      issue(OP_NOP, DT_B, 4'd0, 4'd0, 16'h0);
      chk("rst_seq nop latency", c_lat, 1);
      chk("rst_seq nop ram_en", c_en, 0);

      // Back-to-back: request held valid across a store
      regs[12] = 64'h0300;
      regs[14] = 64'h11;
      @(negedge clk);
      op = OP_STORE; data_type = DT_B; data_reg = 4'd14; addr_reg = 4'd12; addr_offset = 16'h0;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b ready c1", req_ready, 0);
      @(negedge clk);
      chk("b2b done c2", done, 1);
      chk("b2b ready c2", req_ready, 0);
      @(negedge clk);
      chk("b2b ready c3", req_ready, 1);
      op = OP_NOP;
      @(posedge clk);
      @(negedge clk);
      chk("b2b nop done c4", done, 1);
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b done c5", done, 0);
      chk("b2b ready c5", req_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
